// File: rtl/spi_slave_if.sv
// SPI responder endpoint: oversamples SCLK/CS_N/MOSI in the clk_i domain,
// deserialises MOSI into rx words and serialises a one-word tx buffer on MISO.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | CS_N high (or not yet re-armed after reset); SCLK ignored
// ACTIVE | frame in progress; mode/bit order latched at CS_N fall
module spi_slave_if #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_unf_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ack_i,
  output logic              rx_ovr_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
  logic                   sclk_s, cs_s, mosi_s, flushed;
  logic                   sclk_prev, cs_prev;
  logic                   cpol_l, cpha_l, lsb_l;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   first_shift;
  logic [DATA_W-1:0]      tx_sr, tx_buf, rx_sr;

  logic                   cs_fall, cs_rise, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;
  logic                   load, shift_tx, lsb_d, oe_d, miso_d;
  logic [DATA_W-1:0]      tx_sr_d, rx_sr_d;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  // flush tracks when the CS chain holds a real pin sample rather than its
  // reset value, so a CS already low at reset release never looks like a fall
  assign flushed = flush[SYNC_STAGES-1];

  assign cs_fall     = cs_prev & ~cs_s;
  assign cs_rise     = flushed & ~cs_prev & cs_s;
  assign lead_edge   = (sclk_prev == cpol_l) && (sclk_s != cpol_l);
  assign trail_edge  = (sclk_prev != cpol_l) && (sclk_s == cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;

  assign rx_sr_d = lsb_l ? {mosi_s, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_s};

  // Input synchronisers for the asynchronous pad signals
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      flush     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Next value of the tx shift register and of the registered MISO pin
  always_comb begin
    load     = 1'b0;
    shift_tx = 1'b0;
    lsb_d    = lsb_l;
    oe_d     = miso_oe_o;
    if (state == IDLE) begin
      if (cs_fall) begin
        load  = 1'b1;
        lsb_d = lsb_first_i;
        oe_d  = 1'b1;
      end
    end else if (cs_rise) begin
      oe_d = 1'b0;
    end else if (shift_edge) begin
      if (bit_cnt != '0)    shift_tx = 1'b1;
      else if (!first_shift) load    = 1'b1;
    end

    tx_sr_d = tx_sr;
    if (state == ACTIVE && cs_rise)
      tx_sr_d = '0;
    else if (load)
      tx_sr_d = tx_ready_o ? '0 : tx_buf;
    else if (shift_tx)
      tx_sr_d = lsb_l ? (tx_sr >> 1) : (tx_sr << 1);

    miso_d = oe_d & (lsb_d ? tx_sr_d[0] : tx_sr_d[DATA_W-1]);
  end

  // Frame FSM with tx buffer, rx handshake and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      sclk_prev   <= 1'b0;
      cs_prev     <= 1'b0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
      lsb_l       <= 1'b0;
      bit_cnt     <= '0;
      first_shift <= 1'b0;
      tx_sr       <= '0;
      tx_buf      <= '0;
      rx_sr       <= '0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
      tx_ready_o  <= 1'b1;
      tx_unf_o    <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      rx_ovr_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      cs_prev   <= flushed ? cs_s : 1'b0;
      tx_sr     <= tx_sr_d;
      miso_o    <= miso_d;
      miso_oe_o <= oe_d;
      tx_unf_o  <= load & tx_ready_o;
      rx_ovr_o  <= 1'b0;

      // a write can only land in an empty buffer, so it never races a real transfer
      if (tx_valid_i && tx_ready_o) begin
        tx_buf     <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else if (load && !tx_ready_o) begin
        tx_ready_o <= 1'b1;
      end

      if (rx_ack_i && rx_valid_o)
        rx_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            cpol_l      <= cpol_i;
            cpha_l      <= cpha_i;
            lsb_l       <= lsb_first_i;
            bit_cnt     <= '0;
            first_shift <= 1'b1;
            busy_o      <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_sr_d;
              if (bit_cnt == CNT_W'(DATA_W-1)) begin
                bit_cnt    <= '0;
                rx_data_o  <= rx_sr_d;
                rx_valid_o <= 1'b1;
                rx_ovr_o   <= rx_valid_o & ~rx_ack_i;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (shift_edge)
              first_shift <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI responder (slave) endpoint. It is the far end of the link driven by the SPI clock generator and master shifter. It oversamples the external SCLK, CS_N and MOSI pins in the system clock domain and detects SCLK edges per CPOL/CPHA. It deserialises MOSI into words and serialises MISO from a one-word transmit buffer, with valid/ready handshakes toward the AXI register side.

Parameters:
DATA_W, 8, word length in bits (4..32)
SYNC_STAGES, 2, synchroniser depth for sclk_i, cs_n_i and mosi_i (>=2)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
cpol_i  in  1  SCLK idle level
cpha_i  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first_i  in  1  bit order for both directions
sclk_i  in  1  external SPI clock (asynchronous)
cs_n_i  in  1  external chip select, active low (asynchronous)
mosi_i  in  1  external serial data in
miso_o  out  1  serial data out
miso_oe_o  out  1  MISO pad output enable
tx_data_i  in  DATA_W  word to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  tx buffer empty
tx_unf_o  out  1  1-cycle pulse: word loaded while buffer empty
rx_data_o  out  DATA_W  last received word
rx_valid_o  out  1  rx_data_o holds an unread word
rx_ack_i  in  1  consumer read rx_data_o
rx_ovr_o  out  1  1-cycle pulse: word completed while rx_valid_o high
busy_o  out  1  frame in progress

Behaviour:
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, tx_unf_o=0, rx_data_o=0, rx_valid_o=0, rx_ovr_o=0, busy_o=0. Synchroniser reset values: cs=1, sclk=0, mosi=0. FSM in IDLE.
- Input timing: all pins pass SYNC_STAGES flops. Each SCLK phase must be >= 4 clk_i periods, so f_sclk <= f_clk/8.
- Edge detection: sclk_prev register holds the synchronised SCLK. Leading edge = transition away from latched CPOL; trailing edge = return to it. Sample edge is leading if CPHA=0, trailing if CPHA=1. Shift edge is the other.
- FSM IDLE: on synchronised CS falling:
  - latch cpol/cpha/lsb_first; these inputs are ignored until the next frame.
  - set sclk_prev to the current synchronised SCLK; clear bit_cnt.
  - set first_shift=1 and load tx_sr (load rule below).
  - busy_o=1, miso_oe_o=1; go to ACTIVE.
- FSM ACTIVE:
  - Sample edge: shift synchronised MOSI into rx_sr (MSB-first or LSB-first per latched order) and increment bit_cnt. When bit_cnt reaches DATA_W: bit_cnt wraps to 0, rx_data_o gets the full word, rx_valid_o=1 next cycle.
  - Shift edge, bit_cnt!=0: shift tx_sr by one.
  - Shift edge, bit_cnt==0 and first_shift=1: hold tx_sr and clear first_shift. Only reachable with CPHA=1.
  - Shift edge, bit_cnt==0 and first_shift=0: load tx_sr.
  - Any shift edge clears first_shift.
- Load rule:
  - If tx buffer full: tx_sr <= buffer, buffer marked empty, tx_ready_o=1 next cycle.
  - Else: tx_sr <= 0 and tx_unf_o pulses 1 cycle.
- miso_o: tx_sr MSB, or LSB when lsb_first, registered. It is the first bit immediately after CS assertion. It is 0 when miso_oe_o=0.
- TX buffer: accepts a word on tx_valid_i && tx_ready_o; tx_ready_o=0 from the next cycle until the buffer is transferred. A load and a write in the same cycle: the load takes the old content, the new word is stored, and tx_ready_o stays 0.
- RX handshake:
  - rx_ack_i with rx_valid_o=1 clears rx_valid_o next cycle.
  - Word completion while rx_valid_o=1 and no ack the same cycle: overwrite rx_data_o, keep rx_valid_o=1, pulse rx_ovr_o.
  - Completion and ack in the same cycle: new word is valid, no overrun.
- CS deassert (synchronised rising) in ACTIVE: abort.
  - Partial rx_sr is discarded; rx_data_o and rx_valid_o are unchanged; tx_sr contents are discarded.
  - The buffer is untouched if it was not yet transferred.
  - bit_cnt=0, busy_o=0, miso_oe_o=0; go to IDLE.
  - SCLK edges while in IDLE are ignored.
- Reset asserted mid-frame: immediate return to reset values. After release, a frame starts only on a fresh CS falling edge. CS already low at release is ignored until it goes high.

Test Plan:
1. Mode 0 (CPOL=0, CPHA=0), MSB-first, buffer 0xA5, master sends 0x3C in 8 clocks -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C; rx_valid_o=1; tx_ready_o=1 after CS fall.
2. Mode 3 (CPOL=1, CPHA=1), LSB-first, two back-to-back words, buffer 0x81 then 0x7E (written after first load) -> MISO 0x81 then 0x7E LSB-first; rx_valid_o and rx_ack_i sequence with no overrun.
3. Empty buffer at CS fall in mode 1 -> MISO all 0, tx_unf_o one pulse, rx word still captured.
4. Two words received without rx_ack_i -> rx_ovr_o exactly one pulse; rx_data_o = second word; rx_valid_o=1.
5. CS deasserted after 5 SCLK cycles -> busy_o=0, miso_oe_o=0, rx_valid_o unchanged. The next full frame returns the correct word with bit_cnt restarted.
6. reset_i pulsed mid-word with CS held low -> all outputs at reset values; no rx_valid_o until CS rises and falls again and a full frame completes.
